// File: rtl/srrc_coeff_ctrl.sv
// srrc_coeff_ctrl
// Coefficient load/swap controller for the parallel frequency-domain SRRC
// filter. Coefficient words are written one at a time into a shadow bank.
// The full shadow bank is copied into the active bank (H) only at a block
// boundary. The controller also drives the multiplier clear and delays block
// valid/last by the multiplier latency.
//
// Coefficient handshake: a word on coef_data transfers on a rising edge where
// coef_valid & coef_ready are both high. coef_valid may be asserted at any
// time. Words offered while coef_ready is low are not stored. coef_ready does
// not depend on coef_valid.

module srrc_coeff_ctrl #(
  parameter int N        = 16,
  parameter int MULT_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_start,
  input  logic              coef_valid,
  input  logic [15:0]       coef_data,
  output logic              coef_ready,
  input  logic              blk_valid,
  input  logic              blk_last,
  output logic [16*N-1:0]   H,
  output logic              filt_sclr,
  output logic              y_valid,
  output logic              y_last,
  output logic              h_loaded,
  output logic              swap_done,
  output logic [15:0]       drop_cnt,
  output logic [1:0]        state_dbg
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t               state, next_state;
  logic [CW-1:0]        cnt, next_cnt;
  logic [N-1:0][15:0]   shadow;
  logic [N-1:0][15:0]   active;
  logic                 accept;
  logic                 swap_cond;
  logic                 wr_en;
  logic [CW-1:0]        wr_slot;
  logic                 do_swap;
  logic [MULT_LAT-1:0]  vpipe;
  logic [MULT_LAT-1:0]  lpipe;
  logic                 v_in;
  logic                 l_in;

  assign accept    = coef_valid & coef_ready;
  // Swap only between frames or when no block is in the filter this cycle.
  assign swap_cond = ~blk_valid | blk_last;
  assign H         = active;
  assign state_dbg = state;

  // Only blocks that meet a loaded bank enter the output pipeline.
  assign v_in = blk_valid & h_loaded;
  assign l_in = blk_valid & h_loaded & blk_last;

  assign y_valid = vpipe[MULT_LAT-1];
  assign y_last  = lpipe[MULT_LAT-1];

  // Next-state, slot write and swap decode. coef_start overrides everything.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    wr_en      = 1'b0;
    wr_slot    = cnt;
    do_swap    = 1'b0;
    if (coef_start) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            if (N == 1) begin
              next_state = PEND;
              next_cnt   = '0;
            end else begin
              next_state = LOAD;
              next_cnt   = CW'(1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_en = 1'b1;
            if (cnt == CW'(N - 1)) begin
              next_state = PEND;
              next_cnt   = '0;
            end else begin
              next_cnt = cnt + CW'(1);
            end
          end
        end
        PEND: begin
          if (swap_cond) begin
            do_swap    = 1'b1;
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // State, word counter and registered ready (low only while a swap is pending).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      coef_ready <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      coef_ready <= (next_state != PEND);
    end
  end

  // Shadow bank: written one slot per accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[wr_slot] <= coef_data;
    end
  end

  // Active bank, loaded flag and one-cycle swap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= '0;
      h_loaded  <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) begin
        active   <= shadow;
        h_loaded <= 1'b1;
      end
    end
  end

  // Multiplier clear follows the loaded flag one cycle late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_sclr <= 1'b1;
    end else begin
      filt_sclr <= ~h_loaded;
    end
  end

  // Valid/last delay line matching the multiplier latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= v_in;
      lpipe[0] <= l_in;
      for (int i = 1; i < MULT_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  // Saturating count of blocks that arrived before any bank was active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (blk_valid && !h_loaded && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_srrc_coeff_ctrl.sv
// Directed bench for srrc_coeff_ctrl with N=4, MULT_LAT=3.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_srrc_coeff_ctrl;

  localparam int N  = 4;
  localparam int ML = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              coef_start;
  logic              coef_valid;
  logic [15:0]       coef_data;
  logic              coef_ready;
  logic              blk_valid;
  logic              blk_last;
  logic [16*N-1:0]   H;
  logic              filt_sclr;
  logic              y_valid;
  logic              y_last;
  logic              h_loaded;
  logic              swap_done;
  logic [15:0]       drop_cnt;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];

  srrc_coeff_ctrl #(.N(N), .MULT_LAT(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .coef_start (coef_start),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .blk_valid  (blk_valid),
    .blk_last   (blk_last),
    .H          (H),
    .filt_sclr  (filt_sclr),
    .y_valid    (y_valid),
    .y_last     (y_last),
    .h_loaded   (h_loaded),
    .swap_done  (swap_done),
    .drop_cnt   (drop_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock and hard time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] d);
    coef_valid = 1'b1;
    coef_data  = d;
    @(negedge clk);
    coef_valid = 1'b0;
    coef_data  = '0;
  endtask

  initial begin
    int ysum;
    int swaps;
    int hchg;
    logic [1:0] e;
    logic [63:0] h_old;

    reset      = 1'b0;
    coef_start = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    blk_valid  = 1'b0;
    blk_last   = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_H",        H,          64'h0);
    check("rst_h_loaded", h_loaded,   1'b0);
    check("rst_sclr",     filt_sclr,  1'b1);
    check("rst_y_valid",  y_valid,    1'b0);
    check("rst_y_last",   y_last,     1'b0);
    check("rst_swap",     swap_done,  1'b0);
    check("rst_drop",     drop_cnt,   16'd0);
    check("rst_ready",    coef_ready, 1'b0);
    reset = 1'b1;
    step();
    check("ready_after_rst", coef_ready, 1'b1);
    check("state_idle",      state_dbg,  2'd0);

    // Blocks before any bank is loaded are dropped
    ysum = 0;
    blk_valid = 1'b1;
    repeat (5) begin
      step();
      ysum += int'(y_valid);
    end
    blk_valid = 1'b0;
    repeat (4) begin
      step();
      ysum += int'(y_valid);
    end
    check("drop_no_yvalid", ysum,     0);
    check("drop_cnt5",      drop_cnt, 16'd5);
    check("drop_unloaded",  h_loaded, 1'b0);

    // First load with idle block stream: swap right after PEND
    push_word(16'h1000);
    push_word(16'h2000);
    push_word(16'h3000);
    push_word(16'h4000);
    check("pend_ready", coef_ready, 1'b0);
    check("pend_state", state_dbg,  2'd2);
    check("pend_H",     H,          64'h0);
    check("pend_swap",  swap_done,  1'b0);
    step();
    check("swap1_H",      H,         64'h4000_3000_2000_1000);
    check("swap1_pulse",  swap_done, 1'b1);
    check("swap1_loaded", h_loaded,  1'b1);
    check("swap1_sclr",   filt_sclr, 1'b1);
    step();
    check("swap1_pulse_end", swap_done,  1'b0);
    check("sclr_low",        filt_sclr,  1'b0);
    check("ready_idle",      coef_ready, 1'b1);

    // Two blocks, last on the second: y_valid after 3 cycles
    exp_q = {2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
    blk_valid = 1'b1;
    blk_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      e = exp_q.pop_front();
      check($sformatf("ypipe_%0d", i), {y_valid, y_last}, e);
      if (i == 0) blk_last = 1'b1;
      if (i == 1) begin
        blk_valid = 1'b0;
        blk_last  = 1'b0;
      end
    end
    check("drop_hold", drop_cnt, 16'd5);

    // Second set held in PEND by a running frame; ignored words while not ready
    blk_valid = 1'b1;
    blk_last  = 1'b0;
    push_word(16'h0111);
    push_word(16'h0222);
    push_word(16'h0333);
    push_word(16'h0444);
    check("pend2_state", state_dbg,  2'd2);
    check("pend2_ready", coef_ready, 1'b0);
    h_old = H;
    swaps = 0;
    hchg  = 0;
    for (int i = 0; i < 10; i++) begin
      coef_valid = (i < 5);
      coef_data  = 16'hFFFF;
      step();
      swaps += int'(swap_done);
      if (H !== h_old) hchg++;
    end
    coef_valid = 1'b0;
    coef_data  = '0;
    check("hold_no_swap", swaps,     0);
    check("hold_H_chg",   hchg,      0);
    check("hold_H",       H,         64'h4000_3000_2000_1000);
    check("hold_state",   state_dbg, 2'd2);
    blk_last = 1'b1;
    step();
    check("swap2_H",     H,         64'h0444_0333_0222_0111);
    check("swap2_pulse", swap_done, 1'b1);
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    step();
    step();
    check("swap2_blk_out", {y_valid, y_last}, 2'b11);
    step();
    check("swap2_drain", y_valid, 1'b0);

    // coef_start in PEND cancels the pending swap
    swaps = 0;
    blk_valid = 1'b1;
    push_word(16'h0B01);
    push_word(16'h0B02);
    push_word(16'h0B03);
    push_word(16'h0B04);
    coef_start = 1'b1;
    step();
    coef_start = 1'b0;
    blk_valid  = 1'b0;
    swaps += int'(swap_done);
    repeat (3) begin
      step();
      swaps += int'(swap_done);
    end
    check("cancel_no_swap", swaps,      0);
    check("cancel_H",       H,          64'h0444_0333_0222_0111);
    check("cancel_state",   state_dbg,  2'd0);
    check("cancel_ready",   coef_ready, 1'b1);

    // Partial load, restart (with a word in the same cycle), new load
    swaps = 0;
    push_word(16'hAAAA);
    swaps += int'(swap_done);
    push_word(16'hBBBB);
    swaps += int'(swap_done);
    check("partial_ready", coef_ready, 1'b1);
    check("partial_state", state_dbg,  2'd1);
    coef_start = 1'b1;
    coef_valid = 1'b1;
    coef_data  = 16'hDEAD;
    step();
    coef_start = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    swaps += int'(swap_done);
    check("restart_state", state_dbg,  2'd0);
    check("restart_ready", coef_ready, 1'b1);
    push_word(16'h0A01);
    push_word(16'h0A02);
    push_word(16'h0A03);
    swaps += int'(swap_done);
    check("reload_ready", coef_ready, 1'b1);
    push_word(16'h0A04);
    check("reload_pend_ready", coef_ready, 1'b0);
    check("no_stray_swap",     swaps,      0);
    step();
    check("swap3_H",     H,         64'h0A04_0A03_0A02_0A01);
    check("swap3_pulse", swap_done, 1'b1);

    // Reset mid-load with valid blocks in flight
    blk_valid = 1'b1;
    push_word(16'h1111);
    push_word(16'h2222);
    #2;
    reset = 1'b0;
    #1;
    check("arst_H",       H,          64'h0);
    check("arst_drop",    drop_cnt,   16'd0);
    check("arst_loaded",  h_loaded,   1'b0);
    check("arst_sclr",    filt_sclr,  1'b1);
    check("arst_y_valid", y_valid,    1'b0);
    check("arst_y_last",  y_last,     1'b0);
    check("arst_swap",    swap_done,  1'b0);
    check("arst_ready",   coef_ready, 1'b0);
    blk_valid = 1'b0;
    step();
    reset = 1'b1;
    ysum = 0;
    repeat (6) begin
      step();
      ysum += int'(y_valid);
    end
    check("post_rst_no_y", ysum,       0);
    check("post_rst_H",    H,          64'h0);
    check("post_rst_rdy",  coef_ready, 1'b1);
    check("post_rst_drop", drop_cnt,   16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
